// File: rtl/qspi_flash_reader.sv
// SPI / dual / quad flash read engine driving SB_IO pad registers.
// Converts burst requests into command, address, dummy and data phases and
// returns little-endian words through a 2-entry buffer. SCK pauses between
// words when the buffer plus in-flight words would otherwise overflow.
module qspi_flash_reader #(
    parameter int unsigned IO_MODE        = 2,
    parameter int unsigned WORD_BYTES     = 4,
    parameter int unsigned LEN_BITS       = 8,
    parameter int unsigned INPUT_LATENCY  = 2,
    parameter int unsigned CS_HIGH_CYCLES = 4
) (
    input  logic                    clk_2x,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [23:0]             req_addr,
    input  logic [LEN_BITS-1:0]     req_len,
    output logic [8*WORD_BYTES-1:0] rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic                    busy,
    output logic [1:0]              flash_clk_ddr,
    output logic                    flash_csn,
    output logic [3:0]              flash_in,
    output logic [3:0]              flash_in_en,
    input  logic [3:0]              flash_out
);

    localparam int unsigned W       = 8 * WORD_BYTES;
    localparam int unsigned B       = (IO_MODE == 0) ? 1 : (IO_MODE == 1) ? 2 : 4;
    localparam int unsigned SPB     = 8 / B;   // SCKs per byte
    localparam int unsigned SPW     = W / B;   // SCKs per word
    localparam int unsigned HOLD_W  = $clog2(CS_HIGH_CYCLES + 1);
    localparam logic [7:0]  CMD_BYTE = (IO_MODE == 0) ? 8'h03 :
                                       (IO_MODE == 1) ? 8'h3B : 8'h6B;
    localparam logic [3:0]  IN_MASK = 4'((1 << B) - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CMD      = 3'd1;
    localparam logic [2:0] S_ADDR     = 3'd2;
    localparam logic [2:0] S_DUMMY    = 3'd3;
    localparam logic [2:0] S_DATA     = 3'd4;
    localparam logic [2:0] S_DRAIN    = 3'd5;
    localparam logic [2:0] S_CSN_HOLD = 3'd6;

    logic [2:0]               state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic [LEN_BITS-1:0]      word_cnt_q, word_cnt_d;
    logic [LEN_BITS-1:0]      len_q, len_d;
    logic [23:0]              addr_q, addr_d;
    logic                     sck_q, sck_d;
    logic                     data_sck_q, data_sck_d;
    logic                     csn_q, csn_d;
    logic [3:0]               io_q, io_d;
    logic [3:0]               oe_q, oe_d;
    logic [INPUT_LATENCY-1:0] tag_q;
    logic [4:0]               rx_cnt_q, rx_cnt_d;
    logic [7:0]               byte_q, byte_d, byte_new;
    logic [W-1:0]             word_q, word_d, word_new;
    logic [1:0]               inflight_q, inflight_d;
    logic [1:0]               occ_q, occ_d;
    logic                     wptr_q, rptr_q;
    logic [W-1:0]             mem_q [2];
    logic                     busy_q, busy_d;
    logic                     accept, start_word, sample, push, pop;

    assign req_ready     = (state_q == S_IDLE) && !busy_q;
    assign flash_clk_ddr = {sck_q, 1'b0};
    assign flash_csn     = csn_q;
    assign flash_in      = io_q;
    assign flash_in_en   = oe_q;
    assign rd_valid      = (occ_q != 2'd0);
    assign rd_data       = mem_q[rptr_q];
    assign busy          = busy_q;
    assign sample        = tag_q[INPUT_LATENCY-1];
    assign pop           = rd_valid && rd_ready;

    // Transaction sequencer: decides each cycle whether an SCK is issued and what IO0 carries.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        addr_d     = addr_q;
        sck_d      = 1'b0;
        data_sck_d = 1'b0;
        csn_d      = csn_q;
        io_d       = io_q;
        oe_d       = oe_q;
        accept     = 1'b0;
        start_word = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    addr_d     = req_addr;
                    len_d      = req_len;
                    csn_d      = 1'b0;
                    cnt_d      = 5'd0;
                    word_cnt_d = '0;
                    state_d    = S_CMD;
                end
            end
            S_CMD: begin
                sck_d = 1'b1;
                io_d  = {3'b000, CMD_BYTE[3'd7 - cnt_q[2:0]]};
                oe_d  = 4'b0001;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd7) begin
                    cnt_d   = 5'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                sck_d = 1'b1;
                io_d  = {3'b000, addr_q[5'd23 - cnt_q]};
                oe_d  = 4'b0001;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd23) begin
                    cnt_d   = 5'd0;
                    state_d = (IO_MODE == 0) ? S_DATA : S_DUMMY;
                end
            end
            S_DUMMY: begin
                sck_d = 1'b1;
                io_d  = 4'b0000;
                oe_d  = 4'b0000;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd7) begin
                    cnt_d   = 5'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                oe_d = 4'b0000;
                // A word already started is always finished; a new one needs a free slot.
                if (cnt_q != 5'd0 || ({1'b0, occ_q} + {1'b0, inflight_q}) < 3'd2) begin
                    sck_d      = 1'b1;
                    data_sck_d = 1'b1;
                    start_word = (cnt_q == 5'd0);
                    cnt_d      = cnt_q + 5'd1;
                    if (cnt_q == 5'(SPW - 1)) begin
                        cnt_d = 5'd0;
                        if (word_cnt_q == len_q) begin
                            state_d = S_DRAIN;
                        end else begin
                            word_cnt_d = word_cnt_q + LEN_BITS'(1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (inflight_q == 2'd0) begin
                    csn_d   = 1'b1;
                    hold_d  = '0;
                    state_d = S_CSN_HOLD;
                end
            end
            S_CSN_HOLD: begin
                csn_d  = 1'b1;
                oe_d   = 4'b0000;
                hold_d = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_W'(CS_HIGH_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                csn_d   = 1'b1;
                hold_d  = '0;
                state_d = S_CSN_HOLD;
            end
        endcase
    end

    // Receive path: assembles bytes MSB first and packs them little-endian into words.
    always_comb begin
        byte_new = (byte_q << B) | {4'b0000, flash_out & IN_MASK};
        word_new = (word_q >> 8) | (W'(byte_new) << (W - 8));
        byte_d   = byte_q;
        word_d   = word_q;
        rx_cnt_d = rx_cnt_q;
        push     = 1'b0;
        if (sample) begin
            byte_d   = byte_new;
            rx_cnt_d = rx_cnt_q + 5'd1;
            if ((rx_cnt_q & 5'(SPB - 1)) == 5'(SPB - 1)) begin
                word_d = word_new;
            end
            if (rx_cnt_q == 5'(SPW - 1)) begin
                rx_cnt_d = 5'd0;
                push     = 1'b1;
            end
        end
    end

    // Occupancy, in-flight word count and busy tracking.
    always_comb begin
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
        inflight_d = inflight_q + {1'b0, start_word} - {1'b0, push};
        busy_d     = busy_q;
        if (accept) begin
            busy_d = 1'b1;
        end else if (state_d == S_IDLE && occ_d == 2'd0) begin
            busy_d = 1'b0;
        end
    end

    // State and pad registers; reset leaves CSN high and starts in the CSN hold period.
    always_ff @(posedge clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_CSN_HOLD;
            cnt_q      <= 5'd0;
            hold_q     <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            addr_q     <= 24'd0;
            sck_q      <= 1'b0;
            data_sck_q <= 1'b0;
            csn_q      <= 1'b1;
            io_q       <= 4'b0000;
            oe_q       <= 4'b0000;
            tag_q      <= '0;
            rx_cnt_q   <= 5'd0;
            byte_q     <= 8'd0;
            word_q     <= '0;
            inflight_q <= 2'd0;
            occ_q      <= 2'd0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            sck_q      <= sck_d;
            data_sck_q <= data_sck_d;
            csn_q      <= csn_d;
            io_q       <= io_d;
            oe_q       <= oe_d;
            // Tag travels with each data SCK until its bits appear on flash_out.
            tag_q      <= (tag_q << 1) | INPUT_LATENCY'(data_sck_q);
            rx_cnt_q   <= rx_cnt_d;
            byte_q     <= byte_d;
            word_q     <= word_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            busy_q     <= busy_d;
            if (push) wptr_q <= ~wptr_q;
            if (pop)  rptr_q <= ~rptr_q;
        end
    end

    // Buffer storage; contents are qualified by occupancy so no reset is needed.
    always_ff @(posedge clk_2x) begin
        if (push) begin
            mem_q[wptr_q] <= word_new;
        end
    end

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Directed bench: three reader instances (single/WB1, dual/WB2, quad/WB4)
// against a behavioural flash model with a fixed input latency.
module tb_qspi_flash_reader;

    localparam int LAT = 2;

    logic clk_2x = 1'b0;
    always #5 clk_2x = ~clk_2x;

    logic        reset_n;
    logic        rqv [3];
    logic        rqr [3];
    logic        rv  [3];
    logic        rdy [3];
    logic        bsy [3];
    logic        csn [3];
    logic [23:0] addr [3];
    logic [7:0]  len  [3];
    logic [1:0]  ddr  [3];
    logic [3:0]  fin  [3];
    logic [3:0]  fen  [3];
    logic [3:0]  fout [3];
    logic [7:0]  rdd0;
    logic [15:0] rdd1;
    logic [31:0] rdd2;

    qspi_flash_reader #(.IO_MODE(0), .WORD_BYTES(1), .LEN_BITS(8), .INPUT_LATENCY(LAT),
                        .CS_HIGH_CYCLES(4)) u_m0 (
        .clk_2x(clk_2x), .reset_n(reset_n), .req_valid(rqv[0]), .req_ready(rqr[0]),
        .req_addr(addr[0]), .req_len(len[0]), .rd_data(rdd0), .rd_valid(rv[0]),
        .rd_ready(rdy[0]), .busy(bsy[0]), .flash_clk_ddr(ddr[0]), .flash_csn(csn[0]),
        .flash_in(fin[0]), .flash_in_en(fen[0]), .flash_out(fout[0]));

    qspi_flash_reader #(.IO_MODE(1), .WORD_BYTES(2), .LEN_BITS(8), .INPUT_LATENCY(LAT),
                        .CS_HIGH_CYCLES(4)) u_m1 (
        .clk_2x(clk_2x), .reset_n(reset_n), .req_valid(rqv[1]), .req_ready(rqr[1]),
        .req_addr(addr[1]), .req_len(len[1]), .rd_data(rdd1), .rd_valid(rv[1]),
        .rd_ready(rdy[1]), .busy(bsy[1]), .flash_clk_ddr(ddr[1]), .flash_csn(csn[1]),
        .flash_in(fin[1]), .flash_in_en(fen[1]), .flash_out(fout[1]));

    qspi_flash_reader #(.IO_MODE(2), .WORD_BYTES(4), .LEN_BITS(8), .INPUT_LATENCY(LAT),
                        .CS_HIGH_CYCLES(4)) u_m2 (
        .clk_2x(clk_2x), .reset_n(reset_n), .req_valid(rqv[2]), .req_ready(rqr[2]),
        .req_addr(addr[2]), .req_len(len[2]), .rd_data(rdd2), .rd_valid(rv[2]),
        .rd_ready(rdy[2]), .busy(bsy[2]), .flash_clk_ddr(ddr[2]), .flash_csn(csn[2]),
        .flash_in(fin[2]), .flash_in_en(fen[2]), .flash_out(fout[2]));

    // Flash model state
    logic [7:0]  mem [256];
    int          nsck [3];
    int          last_n [3];
    int          hi_run [3];
    int          min_hi [3];
    logic        prev_csn [3];
    logic [7:0]  cmd_sh [3];
    logic [23:0] adr_sh [3];
    logic [3:0]  dly [3][LAT+1];
    int          sck_hi_err;
    logic [31:0] rx_q [$];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flash model and read collector, evaluated mid-cycle.
    initial begin
        logic [3:0] v;
        logic [7:0] by;
        int k, b, d, j, bp;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            nsck[i] = 0; last_n[i] = 0; hi_run[i] = 0; min_hi[i] = 1000;
            prev_csn[i] = 1'b1; cmd_sh[i] = 8'h00; adr_sh[i] = 24'h0; fout[i] = 4'h0;
            for (int s = 0; s <= LAT; s++) dly[i][s] = 4'h0;
        end
        sck_hi_err = 0;
        forever begin
            @(negedge clk_2x);
            for (int i = 0; i < 3; i++) begin
                v = 4'h0;
                b = (i == 0) ? 1 : (i == 1) ? 2 : 4;
                d = (i == 0) ? 32 : 40;
                if (csn[i]) begin
                    if (ddr[i] != 2'b00) sck_hi_err++;
                    if (!prev_csn[i]) last_n[i] = nsck[i];
                    nsck[i] = 0;
                    hi_run[i]++;
                end else begin
                    if (prev_csn[i]) begin
                        if (hi_run[i] < min_hi[i]) min_hi[i] = hi_run[i];
                        hi_run[i] = 0;
                    end
                    if (ddr[i] == 2'b10) begin
                        k = nsck[i];
                        if (k < 8) begin
                            cmd_sh[i] = {cmd_sh[i][6:0], fin[i][0]};
                        end else if (k < 32) begin
                            adr_sh[i] = {adr_sh[i][22:0], fin[i][0]};
                        end else if (k >= d) begin
                            j  = k - d;
                            bp = j * b;
                            by = mem[8'(adr_sh[i][7:0] + 8'(bp / 8))];
                            v  = 4'((by >> (8 - b - (bp % 8))) & ((1 << b) - 1));
                        end
                        nsck[i]++;
                    end
                end
                prev_csn[i] = csn[i];
                for (int s = LAT; s > 0; s--) dly[i][s] = dly[i][s-1];
                dly[i][0] = v;
                fout[i] = dly[i][LAT];
                if (rv[i] && rdy[i]) begin
                    rx_q.push_back((i == 0) ? 32'(rdd0) : (i == 1) ? 32'(rdd1) : rdd2);
                end
            end
        end
    end

    function automatic logic [31:0] rx_at(input int k);
        return (k < rx_q.size()) ? rx_q[k] : 32'hDEAD_BEEF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_2x);
        #1;
    endtask

    task automatic send_req(input int i, input logic [23:0] a, input logic [7:0] l);
        int t;
        addr[i] = a; len[i] = l; rqv[i] = 1'b1; t = 0;
        do begin
            @(negedge clk_2x);
            t++;
        end while (!rqr[i] && t < 200);
        check_eq("req_accept", {31'b0, rqr[i]}, 32'd1);
        @(posedge clk_2x);
        #1;
        rqv[i] = 1'b0;
    endtask

    task automatic wait_words(input int n, input int bound);
        int t;
        t = 0;
        while (rx_q.size() < n && t < bound) begin
            tick(1);
            t++;
        end
        check_eq("words_arrived", rx_q.size(), n);
    endtask

    task automatic wait_idle(input int i);
        int t;
        t = 0;
        while (bsy[i] && t < 300) begin
            tick(1);
            t++;
        end
        tick(1);
        check_eq("busy_drop", {31'b0, bsy[i]}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, acc, t;
        for (int i = 0; i < 3; i++) begin
            rqv[i] = 1'b0; rdy[i] = 1'b1; addr[i] = 24'h0; len[i] = 8'h0;
        end
        reset_n = 1'b0;
        tick(3);
        check_eq("rst_csn",   {31'b0, csn[2]}, 32'd1);
        check_eq("rst_clk",   {30'b0, ddr[2]}, 32'd0);
        check_eq("rst_in",    {28'b0, fin[2]}, 32'd0);
        check_eq("rst_in_en", {28'b0, fen[2]}, 32'd0);
        check_eq("rst_rv",    {31'b0, rv[2]},  32'd0);
        check_eq("rst_busy",  {31'b0, bsy[2]}, 32'd0);
        check_eq("rst_ready", {31'b0, rqr[2]}, 32'd0);
        reset_n = 1'b1;
        tick(1);
        check_eq("ready_in_hold", {31'b0, rqr[2]}, 32'd0);
        tick(6);
        check_eq("ready_after_hold", {31'b0, rqr[2]}, 32'd1);

        // Single mode, one byte
        mem[8'h56] = 8'hA5;
        rx_q.delete();
        send_req(0, 24'h123456, 8'd0);
        wait_words(1, 300);
        check_eq("m0_word", rx_at(0), 32'h0000_00A5);
        wait_idle(0);
        check_eq("m0_cmd",  {24'b0, cmd_sh[0]}, 32'h03);
        check_eq("m0_addr", {8'b0, adr_sh[0]},  32'h123456);
        check_eq("m0_nsck", last_n[0], 32'd40);

        // Quad mode, 4-word burst
        for (int a = 0; a < 16; a++) mem[a] = 8'(a);
        rx_q.delete();
        send_req(2, 24'h000100, 8'd3);
        wait_words(4, 500);
        check_eq("m2_w0", rx_at(0), 32'h0302_0100);
        check_eq("m2_w1", rx_at(1), 32'h0706_0504);
        check_eq("m2_w2", rx_at(2), 32'h0B0A_0908);
        check_eq("m2_w3", rx_at(3), 32'h0F0E_0D0C);
        wait_idle(2);
        check_eq("m2_cmd",  {24'b0, cmd_sh[2]}, 32'h6B);
        check_eq("m2_addr", {8'b0, adr_sh[2]},  32'h000100);
        check_eq("m2_nsck", last_n[2], 32'd72);

        // Quad mode with consumer backpressure after the first word
        rx_q.delete();
        send_req(2, 24'h000100, 8'd3);
        wait_words(1, 300);
        rdy[2] = 1'b0;
        tick(20);
        s0 = nsck[2];
        tick(30);
        check_eq("bp_sck_paused", nsck[2], s0);
        check_eq("bp_csn_low", {31'b0, csn[2]}, 32'd0);
        check_eq("bp_rv_held", {31'b0, rv[2]}, 32'd1);
        rdy[2] = 1'b1;
        wait_words(4, 500);
        wait_idle(2);
        check_eq("bp_count", rx_q.size(), 32'd4);
        check_eq("bp_w0", rx_at(0), 32'h0302_0100);
        check_eq("bp_w1", rx_at(1), 32'h0706_0504);
        check_eq("bp_w2", rx_at(2), 32'h0B0A_0908);
        check_eq("bp_w3", rx_at(3), 32'h0F0E_0D0C);
        check_eq("bp_nsck", last_n[2], 32'd72);

        // Dual mode, one 16-bit word
        mem[8'h20] = 8'hC3;
        mem[8'h21] = 8'h3C;
        rx_q.delete();
        send_req(1, 24'h000020, 8'd0);
        wait_words(1, 300);
        check_eq("m1_word", rx_at(0), 32'h0000_3CC3);
        wait_idle(1);
        check_eq("m1_cmd",  {24'b0, cmd_sh[1]}, 32'h3B);
        check_eq("m1_nsck", last_n[1], 32'd48);

        // Back-to-back requests with req_valid held
        rx_q.delete();
        addr[0] = 24'h123456; len[0] = 8'd0; rqv[0] = 1'b1;
        acc = 0; t = 0;
        while (acc < 2 && t < 1000) begin
            @(negedge clk_2x);
            if (rqv[0] && rqr[0]) acc++;
            t++;
        end
        check_eq("b2b_accepts", acc, 32'd2);
        @(posedge clk_2x);
        #1;
        rqv[0] = 1'b0;
        wait_words(2, 300);
        wait_idle(0);
        check_eq("b2b_w0", rx_at(0), 32'h0000_00A5);
        check_eq("b2b_w1", rx_at(1), 32'h0000_00A5);
        check_eq("b2b_csn_high_min", {31'b0, (min_hi[0] >= 4)}, 32'd1);

        // Reset in the middle of the data phase
        rx_q.delete();
        send_req(2, 24'h000100, 8'd3);
        t = 0;
        while (nsck[2] < 44 && t < 300) begin
            tick(1);
            t++;
        end
        check_eq("mid_data_reached", {31'b0, (nsck[2] >= 44)}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_csn",   {31'b0, csn[2]}, 32'd1);
        check_eq("mid_rst_in_en", {28'b0, fen[2]}, 32'd0);
        check_eq("mid_rst_clk",   {30'b0, ddr[2]}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check_eq("post_rst_rv",   {31'b0, rv[2]},  32'd0);
        check_eq("post_rst_busy", {31'b0, bsy[2]}, 32'd0);
        tick(8);
        rx_q.delete();
        send_req(2, 24'h000104, 8'd1);
        wait_words(2, 400);
        wait_idle(2);
        check_eq("post_rst_w0", rx_at(0), 32'h0706_0504);
        check_eq("post_rst_w1", rx_at(1), 32'h0B0A_0908);
        check_eq("post_rst_count", rx_q.size(), 32'd2);

        check_eq("no_sck_csn_high", sck_hi_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
